cv32e41s_rvfi_data_trans_fifo: RTL and testbench
================================================

CV32E41S_RVFI_DATA_TRANS_FIFO -- requirements
Module: cv32e41s_rvfi_data_trans_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of entries; legal values are powers of two, 2..8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port trans_valid_i, input, 1 bit: a rotated data OBI request is accepted this cycle.
REQ-005 SHALL have ports trans_addr_i (32 bits), trans_we_i (1), trans_be_i (4) and trans_wdata_i (32), all inputs: the request fields.
REQ-006 SHALL have ports resp_valid_i (1), resp_rdata_i (32) and resp_err_i (1), all inputs: the in-order OBI response.
REQ-007 SHALL have port wb_pop_i, input, 1 bit: a load/store retires in WB and consumes the head entry.
REQ-008 SHALL have port out_valid_o, output, 1 bit: the FIFO is non-empty.
REQ-009 SHALL have ports out_addr_o, out_we_o, out_be_o and out_wdata_o, outputs, same widths as the request: the head request fields.
REQ-010 SHALL have ports out_rdata_o (32) and out_err_o (1), outputs: the head response.
REQ-011 SHALL have port out_resp_done_o, output, 1 bit: the head response is available, stored or bypassed.
REQ-012 SHALL have port count_o, output, clog2(DEPTH)+1 bits: the occupancy.
REQ-013 SHALL have ports overflow_o and protocol_err_o, outputs, 1 bit each: sticky error flags.

Function
REQ-014 SHALL keep entries in a circular buffer addressed by wr_ptr, rd_ptr and rsp_ptr.
- Each pointer is clog2(DEPTH) bits and wraps modulo DEPTH.
REQ-015 SHALL define a push as trans_valid_i=1 that is accepted under REQ-021.
- A push writes addr, we, be and wdata at wr_ptr, clears that entry's resp flag, increments wr_ptr, then count_o.
REQ-016 SHALL keep a pending counter of pushed entries that still lack a response.
REQ-017 SHALL apply resp_valid_i with pending>0 to entry rsp_ptr.
- Stores rdata and err, sets the resp flag, increments rsp_ptr, decrements pending.
REQ-018 SHALL drive the head outputs combinationally from entry rd_ptr.
- Bypass case: the head resp flag is 0, resp_valid_i=1 and rsp_ptr==rd_ptr.
- In that case out_rdata_o/out_err_o show resp_rdata_i/resp_err_i and out_resp_done_o=1.
REQ-019 SHALL drive out_rdata_o and out_err_o to 0 whenever out_resp_done_o=0.
REQ-020 SHALL perform a pop only when wb_pop_i=1, out_valid_o=1 and out_resp_done_o=1.
- A pop increments rd_ptr and decrements count_o; the pop completes in the same cycle, with zero latency.
REQ-021 SHALL accept a push when count_o<DEPTH, or when count_o==DEPTH and a pop happens in the same cycle.
- Otherwise the push is dropped and overflow_o is set.
REQ-022 SHALL allow a push, a response and a pop in the same cycle; each pointer and counter updates independently.
- count_o changes by push minus pop; pending changes by push minus response.
- A push into an empty FIFO becomes visible at the head on the next cycle, with no push-to-output bypass.
REQ-023 SHALL set protocol_err_o in each of these cases, with no state change:
- wb_pop_i=1 when out_valid_o=0;
- wb_pop_i=1 when out_resp_done_o=0;
- resp_valid_i=1 when pending==0 (the response is discarded).
REQ-024 SHALL hold overflow_o and protocol_err_o at 1 until reset once set.
REQ-025 SHALL have no combinational path from wb_pop_i to any output.

Reset
REQ-026 SHALL, on rst=1 (asynchronous), immediately clear all pointers, pending, count_o, the resp flags, overflow_o and protocol_err_o.
- Entries in flight mid-operation are discarded.
REQ-027 SHALL, during and after reset, drive out_valid_o=0, out_resp_done_o=0 and all out_* data fields to 0 until the first push.
- Entry payload storage itself needs no reset.
REQ-028 SHALL ignore trans_valid_i, resp_valid_i and wb_pop_i while rst=1.

Verification
REQ-029 SHALL be verified with a load round trip:
- Stimulus: push addr=0x100, we=0; next cycle response rdata=0xDEADBEEF; next cycle pop.
- Required: out_resp_done_o=1 one cycle after the response, out_rdata_o=0xDEADBEEF, count_o goes 1->1->0.
REQ-030 SHALL be verified with response bypass:
- Stimulus: one pushed entry with no response; resp_valid_i=1, rdata=0x12345678 and wb_pop_i=1 in the same cycle.
- Required: pop happens, out_rdata_o=0x12345678 in that cycle, count_o=0 next, protocol_err_o=0.
REQ-031 SHALL be verified with full-FIFO behaviour (DEPTH=2):
- Stimulus: three pushes with no pop; then, with the FIFO full again, a push and a pop in one cycle.
- Required: overflow_o=1 after the third push with count_o=2; the simultaneous push/pop is accepted with count_o=2.
REQ-032 SHALL be verified with a wrap-around sequence:
- Stimulus: 10 sequential store push/response/pop cycles with wdata=i.
- Required: the head shows wdata 0..9 in order, and the pointers wrap with no error.
REQ-033 SHALL be verified with each protocol-error case:
- Stimulus: pop while empty; pop before response; a response with pending=0.
- Required: protocol_err_o=1 after each case (check each separately), with count_o unchanged.
REQ-034 SHALL be verified with reset mid-operation:
- Stimulus: 2 entries held with 1 pending response; assert rst asynchronously between clock edges.
- Required: out_valid_o=0 and count_o=0 immediately; a subsequent response sets protocol_err_o.

Source files
------------

// File: rtl/cv32e41s_rvfi_data_trans_fifo.sv
// cv32e41s_rvfi_data_trans_fifo
//   Tracks data-side OBI transactions from request acceptance until the
//   matching load/store retires in WB. Each entry holds the request fields
//   and, once it arrives, the in-order response. The head entry is presented
//   combinationally. A response that arrives for the head in the same cycle
//   is bypassed straight to the head outputs.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   trans_valid_i, trans_*_i      accepted request (addr/we/be/wdata)
//   resp_valid_i, resp_rdata_i,
//   resp_err_i                    in-order response
//   wb_pop_i                      retirement in WB, consumes the head
//   out_valid_o, out_*_o          head entry request fields (0 when empty)
//   out_rdata_o, out_err_o        head response (0 until available)
//   out_resp_done_o               head response available (stored or bypassed)
//   count_o                       occupancy
//   overflow_o, protocol_err_o    sticky error flags
module cv32e41s_rvfi_data_trans_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       trans_valid_i,
  input  logic [31:0]                trans_addr_i,
  input  logic                       trans_we_i,
  input  logic [3:0]                 trans_be_i,
  input  logic [31:0]                trans_wdata_i,
  input  logic                       resp_valid_i,
  input  logic [31:0]                resp_rdata_i,
  input  logic                       resp_err_i,
  input  logic                       wb_pop_i,
  output logic                       out_valid_o,
  output logic [31:0]                out_addr_o,
  output logic                       out_we_o,
  output logic [3:0]                 out_be_o,
  output logic [31:0]                out_wdata_o,
  output logic [31:0]                out_rdata_o,
  output logic                       out_err_o,
  output logic                       out_resp_done_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o,
  output logic                       protocol_err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Payload storage (not reset; only read while the control state marks it live)
  logic [31:0] r_addr  [DEPTH];
  logic        r_we    [DEPTH];
  logic [3:0]  r_be    [DEPTH];
  logic [31:0] r_wdata [DEPTH];
  logic [31:0] r_rdata [DEPTH];
  logic        r_err   [DEPTH];

  // Control state
  logic [DEPTH-1:0] r_resp_flag;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_rsp_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_pending;
  logic             r_overflow;
  logic             r_protocol_err;

  logic w_valid;
  logic w_head_resp;
  logic w_bypass;
  logic w_resp_done;
  logic w_pop;
  logic w_push;
  logic w_resp;
  logic w_pop_err;
  logic w_resp_err;
  logic w_overflow_evt;

  assign w_valid     = (r_count != '0);
  assign w_head_resp = r_resp_flag[r_rd_ptr];
  assign w_resp      = resp_valid_i && (r_pending != '0);
  // The incoming response belongs to the head only when the head is the
  // oldest entry still waiting, i.e. rsp_ptr points at it.
  assign w_bypass    = !w_head_resp && w_resp && (r_rsp_ptr == r_rd_ptr);
  assign w_resp_done = w_valid && (w_head_resp || w_bypass);

  assign w_pop          = wb_pop_i && w_resp_done;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push         = trans_valid_i && ((r_count != FULL_CNT) || w_pop);
  assign w_pop_err      = wb_pop_i && !w_resp_done;
  assign w_resp_err     = resp_valid_i && (r_pending == '0);
  assign w_overflow_evt = trans_valid_i && !w_push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_rsp_ptr      <= '0;
      r_count        <= '0;
      r_pending      <= '0;
      r_resp_flag    <= '0;
      r_overflow     <= 1'b0;
      r_protocol_err <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
      if (w_resp) r_rsp_ptr <= r_rsp_ptr + PTR_W'(1);
      r_count   <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      r_pending <= r_pending + CNT_W'(w_push) - CNT_W'(w_resp);
      // Full FIFO with a bypassed pop and a push: both hit the same slot.
      // The clear for the new entry must win, so it is written last.
      if (w_resp) r_resp_flag[r_rsp_ptr] <= 1'b1;
      if (w_push) r_resp_flag[r_wr_ptr]  <= 1'b0;
      if (w_overflow_evt)          r_overflow     <= 1'b1;
      if (w_pop_err || w_resp_err) r_protocol_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr]  <= trans_addr_i;
      r_we[r_wr_ptr]    <= trans_we_i;
      r_be[r_wr_ptr]    <= trans_be_i;
      r_wdata[r_wr_ptr] <= trans_wdata_i;
    end
    if (w_resp) begin
      r_rdata[r_rsp_ptr] <= resp_rdata_i;
      r_err[r_rsp_ptr]   <= resp_err_i;
    end
  end

  assign out_valid_o     = w_valid;
  assign out_addr_o      = w_valid ? r_addr[r_rd_ptr]  : '0;
  assign out_we_o        = w_valid ? r_we[r_rd_ptr]    : 1'b0;
  assign out_be_o        = w_valid ? r_be[r_rd_ptr]    : '0;
  assign out_wdata_o     = w_valid ? r_wdata[r_rd_ptr] : '0;
  assign out_resp_done_o = w_resp_done;
  assign out_rdata_o     = !w_resp_done ? '0   : (w_head_resp ? r_rdata[r_rd_ptr] : resp_rdata_i);
  assign out_err_o       = !w_resp_done ? 1'b0 : (w_head_resp ? r_err[r_rd_ptr]   : resp_err_i);
  assign count_o         = r_count;
  assign overflow_o      = r_overflow;
  assign protocol_err_o  = r_protocol_err;

endmodule

// File: tb/tb_cv32e41s_rvfi_data_trans_fifo.sv
// Testbench for cv32e41s_rvfi_data_trans_fifo: directed scenarios with
// literal expectations, then randomized traffic checked every cycle against
// a queue-based model of the transaction tracker.
module tb_cv32e41s_rvfi_data_trans_fifo;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          trans_valid_i = 1'b0;
  logic [31:0]   trans_addr_i  = '0;
  logic          trans_we_i    = 1'b0;
  logic [3:0]    trans_be_i    = '0;
  logic [31:0]   trans_wdata_i = '0;
  logic          resp_valid_i  = 1'b0;
  logic [31:0]   resp_rdata_i  = '0;
  logic          resp_err_i    = 1'b0;
  logic          wb_pop_i      = 1'b0;
  logic          out_valid_o;
  logic [31:0]   out_addr_o;
  logic          out_we_o;
  logic [3:0]    out_be_o;
  logic [31:0]   out_wdata_o;
  logic [31:0]   out_rdata_o;
  logic          out_err_o;
  logic          out_resp_done_o;
  logic [CW-1:0] count_o;
  logic          overflow_o;
  logic          protocol_err_o;

  cv32e41s_rvfi_data_trans_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .trans_valid_i(trans_valid_i), .trans_addr_i(trans_addr_i),
    .trans_we_i(trans_we_i), .trans_be_i(trans_be_i), .trans_wdata_i(trans_wdata_i),
    .resp_valid_i(resp_valid_i), .resp_rdata_i(resp_rdata_i), .resp_err_i(resp_err_i),
    .wb_pop_i(wb_pop_i),
    .out_valid_o(out_valid_o), .out_addr_o(out_addr_o), .out_we_o(out_we_o),
    .out_be_o(out_be_o), .out_wdata_o(out_wdata_o), .out_rdata_o(out_rdata_o),
    .out_err_o(out_err_o), .out_resp_done_o(out_resp_done_o), .count_o(count_o),
    .overflow_o(overflow_o), .protocol_err_o(protocol_err_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          has_resp;
    logic [31:0] rdata;
    logic        err;
  } ent_t;

  ent_t q[$];
  bit   m_ovf  = 1'b0;
  bit   m_perr = 1'b0;

  function automatic int m_pending();
    int p = 0;
    foreach (q[k]) if (!q[k].has_resp) p++;
    return p;
  endfunction

  // Head response is available if already stored, or if a response arrives
  // now while the head is the oldest entry waiting for one (responses are in order).
  function automatic bit m_done(input bit rv);
    if (q.size() == 0) return 1'b0;
    return q[0].has_resp || rv;
  endfunction

  bit   mu_done, mu_pop, mu_rsp, mu_push, mu_found;
  ent_t mu_e;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_ovf  = 1'b0;
      m_perr = 1'b0;
    end else begin
      mu_done = m_done(resp_valid_i);
      mu_rsp  = resp_valid_i && (m_pending() > 0);
      mu_pop  = wb_pop_i && mu_done;
      mu_push = trans_valid_i && ((q.size() < DEPTH) || mu_pop);
      if (wb_pop_i && !mu_done) m_perr = 1'b1;
      if (resp_valid_i && m_pending() == 0) m_perr = 1'b1;
      if (trans_valid_i && !mu_push) m_ovf = 1'b1;
      if (mu_rsp) begin
        mu_found = 1'b0;
        for (int k = 0; k < q.size(); k++) begin
          if (!mu_found && !q[k].has_resp) begin
            q[k].has_resp = 1'b1;
            q[k].rdata    = resp_rdata_i;
            q[k].err      = resp_err_i;
            mu_found      = 1'b1;
          end
        end
      end
      if (mu_pop) void'(q.pop_front());
      if (mu_push) begin
        mu_e.addr     = trans_addr_i;
        mu_e.we       = trans_we_i;
        mu_e.be       = trans_be_i;
        mu_e.wdata    = trans_wdata_i;
        mu_e.has_resp = 1'b0;
        mu_e.rdata    = '0;
        mu_e.err      = 1'b0;
        q.push_back(mu_e);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit          c_valid, c_done;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        c_we, c_err;
  logic [3:0]  c_be;

  always @(negedge clk) begin
    c_valid = (q.size() > 0);
    c_done  = m_done(resp_valid_i);
    c_addr = '0; c_we = 1'b0; c_be = '0; c_wdata = '0; c_rdata = '0; c_err = 1'b0;
    if (c_valid) begin
      c_addr = q[0].addr; c_we = q[0].we; c_be = q[0].be; c_wdata = q[0].wdata;
      if (c_done) begin
        c_rdata = q[0].has_resp ? q[0].rdata : resp_rdata_i;
        c_err   = q[0].has_resp ? q[0].err   : resp_err_i;
      end
    end
    chk("cmp.valid", 32'(out_valid_o), 32'(c_valid));
    chk("cmp.done",  32'(out_resp_done_o), 32'(c_done));
    chk("cmp.addr",  out_addr_o, c_addr);
    chk("cmp.we",    32'(out_we_o), 32'(c_we));
    chk("cmp.be",    32'(out_be_o), 32'(c_be));
    chk("cmp.wdata", out_wdata_o, c_wdata);
    chk("cmp.rdata", out_rdata_o, c_rdata);
    chk("cmp.err",   32'(out_err_o), 32'(c_err));
    chk("cmp.count", 32'(count_o), 32'(q.size()));
    chk("cmp.ovf",   32'(overflow_o), 32'(m_ovf));
    chk("cmp.perr",  32'(protocol_err_o), 32'(m_perr));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    trans_valid_i = 1'b0; trans_addr_i = '0; trans_we_i = 1'b0; trans_be_i = '0;
    trans_wdata_i = '0; resp_valid_i = 1'b0; resp_rdata_i = '0; resp_err_i = 1'b0;
    wb_pop_i = 1'b0;
  endtask

  // Reset raised between clock edges; effects must show before the next edge.
  task automatic async_reset(input string nm);
    idle();
    #2;
    rst = 1'b1;
    #1;
    chk({nm, ".rst_valid"}, 32'(out_valid_o), 32'd0);
    chk({nm, ".rst_count"}, 32'(count_o), 32'd0);
    chk({nm, ".rst_done"},  32'(out_resp_done_o), 32'd0);
    chk({nm, ".rst_addr"},  out_addr_o, 32'd0);
    chk({nm, ".rst_perr"},  32'(protocol_err_o), 32'd0);
    chk({nm, ".rst_ovf"},   32'(overflow_o), 32'd0);
    tick();
    rst = 1'b0;
  endtask

  bit legal;

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.valid", 32'(out_valid_o), 32'd0);
    chk("reset.count", 32'(count_o), 32'd0);
    chk("reset.done",  32'(out_resp_done_o), 32'd0);
    chk("reset.ovf",   32'(overflow_o), 32'd0);
    chk("reset.perr",  32'(protocol_err_o), 32'd0);
    rst = 1'b0;

    // Load round trip
    trans_valid_i = 1'b1; trans_addr_i = 32'h100; trans_be_i = 4'hF;
    tick(); idle();
    chk("load.count1", 32'(count_o), 32'd1);
    chk("load.valid",  32'(out_valid_o), 32'd1);
    chk("load.nodone", 32'(out_resp_done_o), 32'd0);
    chk("load.rdata0", out_rdata_o, 32'd0);
    resp_valid_i = 1'b1; resp_rdata_i = 32'hDEADBEEF;
    tick(); idle();
    chk("load.done",   32'(out_resp_done_o), 32'd1);
    chk("load.rdata",  out_rdata_o, 32'hDEADBEEF);
    chk("load.count2", 32'(count_o), 32'd1);
    chk("load.addr",   out_addr_o, 32'h100);
    wb_pop_i = 1'b1;
    tick(); idle();
    chk("load.count3", 32'(count_o), 32'd0);
    chk("load.perr",   32'(protocol_err_o), 32'd0);

    // Response bypass with same-cycle pop
    trans_valid_i = 1'b1; trans_addr_i = 32'h200;
    tick(); idle();
    resp_valid_i = 1'b1; resp_rdata_i = 32'h12345678; wb_pop_i = 1'b1;
    #1;
    chk("byp.done",  32'(out_resp_done_o), 32'd1);
    chk("byp.rdata", out_rdata_o, 32'h12345678);
    tick(); idle();
    chk("byp.count", 32'(count_o), 32'd0);
    chk("byp.perr",  32'(protocol_err_o), 32'd0);

    // Full FIFO
    trans_valid_i = 1'b1; trans_addr_i = 32'h300;
    tick(); trans_addr_i = 32'h304;
    tick();
    chk("full.count2", 32'(count_o), 32'd2);
    chk("full.noovf",  32'(overflow_o), 32'd0);
    trans_addr_i = 32'h308;
    tick(); idle();
    chk("full.ovf",    32'(overflow_o), 32'd1);
    chk("full.count3", 32'(count_o), 32'd2);
    chk("full.head",   out_addr_o, 32'h300);
    resp_valid_i = 1'b1; resp_rdata_i = 32'd1;
    tick(); resp_rdata_i = 32'd2;
    tick(); idle();
    trans_valid_i = 1'b1; trans_addr_i = 32'h30C; wb_pop_i = 1'b1;
    tick(); idle();
    chk("full.pp_count", 32'(count_o), 32'd2);
    chk("full.pp_head",  out_addr_o, 32'h304);
    chk("full.pp_rdata", out_rdata_o, 32'd2);
    async_reset("full");

    // Wrap-around with stores
    for (int i = 0; i < 10; i++) begin
      trans_valid_i = 1'b1; trans_we_i = 1'b1; trans_be_i = 4'hF;
      trans_addr_i = 32'h400 + 32'(4 * i); trans_wdata_i = 32'(i);
      tick(); idle();
      resp_valid_i = 1'b1;
      tick(); idle();
      chk("wrap.wdata", out_wdata_o, 32'(i));
      chk("wrap.we",    32'(out_we_o), 32'd1);
      wb_pop_i = 1'b1;
      tick(); idle();
    end
    chk("wrap.count", 32'(count_o), 32'd0);
    chk("wrap.perr",  32'(protocol_err_o), 32'd0);
    chk("wrap.ovf",   32'(overflow_o), 32'd0);

    // Protocol errors
    wb_pop_i = 1'b1;
    tick(); idle();
    chk("perr_empty.flag",  32'(protocol_err_o), 32'd1);
    chk("perr_empty.count", 32'(count_o), 32'd0);
    async_reset("perr_empty");

    trans_valid_i = 1'b1;
    tick(); idle();
    wb_pop_i = 1'b1;
    tick(); idle();
    chk("perr_noresp.flag",  32'(protocol_err_o), 32'd1);
    chk("perr_noresp.count", 32'(count_o), 32'd1);
    async_reset("perr_noresp");

    trans_valid_i = 1'b1;
    tick(); idle();
    resp_valid_i = 1'b1;
    tick(); idle();
    chk("perr_resp.before", 32'(protocol_err_o), 32'd0);
    resp_valid_i = 1'b1;
    tick(); idle();
    chk("perr_resp.flag",  32'(protocol_err_o), 32'd1);
    chk("perr_resp.count", 32'(count_o), 32'd1);
    async_reset("perr_resp");

    // Reset mid-operation
    trans_valid_i = 1'b1; trans_addr_i = 32'h500;
    tick(); trans_addr_i = 32'h504; resp_valid_i = 1'b1;
    tick(); idle();
    chk("midrst.count", 32'(count_o), 32'd2);
    async_reset("midrst");
    resp_valid_i = 1'b1;
    tick(); idle();
    chk("midrst.perr", 32'(protocol_err_o), 32'd1);
    async_reset("midrst2");

    // Randomized traffic, alternating free-running and legal-only windows
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) async_reset("rnd");
      legal = ((i / 500) % 2) == 1;
      trans_addr_i  = $urandom;
      trans_we_i    = 1'($urandom_range(0, 1));
      trans_be_i    = 4'($urandom_range(0, 15));
      trans_wdata_i = $urandom;
      resp_rdata_i  = $urandom;
      resp_err_i    = 1'($urandom_range(0, 1));
      resp_valid_i  = ($urandom_range(0, 2) == 0);
      wb_pop_i      = ($urandom_range(0, 2) == 0);
      trans_valid_i = ($urandom_range(0, 1) == 0);
      if (legal) begin
        if (m_pending() == 0) resp_valid_i = 1'b0;
        if (!m_done(resp_valid_i)) wb_pop_i = 1'b0;
        if (q.size() >= DEPTH && !wb_pop_i) trans_valid_i = 1'b0;
      end
      if (!legal && $urandom_range(0, 199) == 0) begin
        #1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
